pwm_divider: RTL and testbench

PWM_DIVIDER -- requirements
Module: pwm_divider

---
 rtl/pwm_scale_pkg.sv | 10 +
 rtl/pwm_divider_if.sv | 12 +
 rtl/pwm_period_meter.sv | 90 +++++++++
 rtl/pwm_divider.sv | 129 ++++++++++++
 tb/tb_pwm_divider.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_scale_pkg.sv
// rtl/pwm_scale_pkg.sv - shared FSM states and default sizing for the PWM divider
package pwm_scale_pkg;

   localparam int DEF_CNT_W = 16;
   localparam int DEF_DIV   = 25;

   typedef enum logic [1:0] {M_IDLE, M_HIGH, M_LOW} meas_state_t;
   typedef enum logic [1:0] {G_IDLE, G_HIGH, G_LOW} gen_state_t;

endpackage

// File: rtl/pwm_divider_if.sv
// rtl/pwm_divider_if.sv - pin bundle between the PWM divider and its environment
interface pwm_divider_if;

   logic pwm_in;
   logic pwm_out;
   logic locked;
   logic overflow;

   modport master (output pwm_in, input pwm_out, input locked, input overflow);
   modport slave  (input pwm_in, output pwm_out, output locked, output overflow);

endinterface

// File: rtl/pwm_period_meter.sv
// rtl/pwm_period_meter.sv - synchronizes pwm_in and measures high/low widths rise to rise
module pwm_period_meter
   import pwm_scale_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] meas_high,
   output logic [CNT_W-1:0] meas_low,
   output logic             meas_valid,
   output logic             sat,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync_a;
   logic             sync_b;
   logic             level_prev;
   logic             rise;
   logic             fall;
   meas_state_t      state;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] low_cnt;

   assign rise = sync_b & ~level_prev;
   assign fall = ~sync_b & level_prev;

   // Combinational so the generator can drop out on the same edge the flag sets.
   assign sat = ((state == M_HIGH) && sync_b && (high_cnt == CNT_MAX)) ||
                ((state == M_LOW) && !sync_b && (low_cnt == CNT_MAX));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a     <= 1'b0;
         sync_b     <= 1'b0;
         level_prev <= 1'b0;
         state      <= M_IDLE;
         high_cnt   <= '0;
         low_cnt    <= '0;
         meas_high  <= '0;
         meas_low   <= '0;
         meas_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         sync_a     <= pwm_in;
         sync_b     <= sync_a;
         level_prev <= sync_b;
         meas_valid <= 1'b0;
         if (sat) begin
            overflow <= 1'b1;
            state    <= M_IDLE;
         end else begin
            case (state)
               M_IDLE: begin
                  if (rise) begin
                     high_cnt <= CNT_ONE;
                     state    <= M_HIGH;
                  end
               end
               M_HIGH: begin
                  if (fall) begin
                     low_cnt <= CNT_ONE;
                     state   <= M_LOW;
                  end else begin
                     high_cnt <= high_cnt + CNT_ONE;
                  end
               end
               M_LOW: begin
                  if (rise) begin
                     meas_high  <= high_cnt;
                     meas_low   <= low_cnt;
                     meas_valid <= 1'b1;
                     high_cnt   <= CNT_ONE;
                     state      <= M_HIGH;
                  end else begin
                     low_cnt <= low_cnt + CNT_ONE;
                  end
               end
               default: state <= M_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/pwm_divider.sv
// rtl/pwm_divider.sv - regenerates pwm_in at DIV times the period with the same duty
module pwm_divider
   import pwm_scale_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int DIV   = DEF_DIV,
   parameter int OUT_W = CNT_W + 8
)
(
   input  logic          clk,
   input  logic          rst_n,
   pwm_divider_if.slave  bus
);

   localparam logic [OUT_W-1:0] DIV_K = OUT_W'(DIV);
   localparam logic [OUT_W-1:0] ONE   = OUT_W'(1);

   logic [CNT_W-1:0] meas_high;
   logic [CNT_W-1:0] meas_low;
   logic             meas_valid;
   logic             sat;
   logic             overflow;

   logic [OUT_W-1:0] new_high;
   logic [OUT_W-1:0] new_low;
   logic [OUT_W-1:0] tgt_high;
   logic [OUT_W-1:0] tgt_low;
   logic [OUT_W-1:0] shadow_high;
   logic [OUT_W-1:0] shadow_low;
   logic             shadow_valid;
   logic [OUT_W-1:0] phase;
   gen_state_t       state;
   logic             pwm_level;
   logic             lock_flag;

   pwm_period_meter #(.CNT_W(CNT_W)) meter (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_in     (bus.pwm_in),
      .meas_high  (meas_high),
      .meas_low   (meas_low),
      .meas_valid (meas_valid),
      .sat        (sat),
      .overflow   (overflow)
   );

   assign new_high = OUT_W'(meas_high) * DIV_K;
   assign new_low  = OUT_W'(meas_low) * DIV_K;

   assign bus.pwm_out  = pwm_level;
   assign bus.locked   = lock_flag;
   assign bus.overflow = overflow;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= G_IDLE;
         phase        <= '0;
         tgt_high     <= '0;
         tgt_low      <= '0;
         shadow_high  <= '0;
         shadow_low   <= '0;
         shadow_valid <= 1'b0;
         pwm_level    <= 1'b0;
         lock_flag    <= 1'b0;
      end else if (sat) begin
         state        <= G_IDLE;
         phase        <= '0;
         shadow_valid <= 1'b0;
         pwm_level    <= 1'b0;
         lock_flag    <= 1'b0;
      end else begin
         case (state)
            G_IDLE: begin
               if (meas_valid) begin
                  tgt_high  <= new_high;
                  tgt_low   <= new_low;
                  phase     <= ONE;
                  state     <= G_HIGH;
                  pwm_level <= 1'b1;
                  lock_flag <= 1'b1;
               end
            end
            G_HIGH: begin
               if (meas_valid) begin
                  shadow_high  <= new_high;
                  shadow_low   <= new_low;
                  shadow_valid <= 1'b1;
               end
               if (phase == tgt_high) begin
                  phase     <= ONE;
                  state     <= G_LOW;
                  pwm_level <= 1'b0;
               end else begin
                  phase <= phase + ONE;
               end
            end
            G_LOW: begin
               if (phase == tgt_low) begin
                  // Period boundary: a measurement landing right now beats the shadow.
                  phase        <= ONE;
                  state        <= G_HIGH;
                  pwm_level    <= 1'b1;
                  shadow_valid <= 1'b0;
                  if (meas_valid) begin
                     tgt_high <= new_high;
                     tgt_low  <= new_low;
                  end else if (shadow_valid) begin
                     tgt_high <= shadow_high;
                     tgt_low  <= shadow_low;
                  end
               end else begin
                  phase <= phase + ONE;
                  if (meas_valid) begin
                     shadow_high  <= new_high;
                     shadow_low   <= new_low;
                     shadow_valid <= 1'b1;
                  end
               end
            end
            default: begin
               state     <= G_IDLE;
               pwm_level <= 1'b0;
               lock_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_divider.sv
// tb/tb_pwm_divider.sv - directed self-checking bench for pwm_divider
module tb_pwm_divider;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   int   mode_a = 0, hi_a = 3, lo_a = 7, ph_a = 0, cur_hi_a = 3, cur_lo_a = 7;
   int   mode_b = 0, ph_b = 0;
   int   rise_b_n = 0;
   int   rise_b_cyc [2];

   pwm_divider_if if_a ();
   pwm_divider_if if_b ();

   pwm_divider #(.CNT_W(8), .DIV(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_a),
      .bus   (if_a)
   );

   pwm_divider #(.CNT_W(16), .DIV(25)) dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .bus   (if_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Input pattern for A: 0 = low, 1 = held high, 2 = hi_a/lo_a periodic.
   initial begin
      if_a.pwm_in = 1'b0;
      forever begin
         @(negedge clk);
         if (mode_a == 0) begin
            if_a.pwm_in = 1'b0;
            ph_a = 0;
         end else if (mode_a == 1) begin
            if_a.pwm_in = 1'b1;
            ph_a = 0;
         end else begin
            if (ph_a == 0) begin
               cur_hi_a = hi_a;
               cur_lo_a = lo_a;
            end
            if_a.pwm_in = (ph_a < cur_hi_a);
            ph_a = (ph_a + 1 == cur_hi_a + cur_lo_a) ? 0 : ph_a + 1;
         end
      end
   end

   // Input pattern for B: 5 high / 5 low once enabled, recording the first two pin rises.
   initial begin
      if_b.pwm_in = 1'b0;
      forever begin
         @(negedge clk);
         if (mode_b != 0) begin
            if (!if_b.pwm_in && (ph_b < 5)) begin
               if (rise_b_n < 2) rise_b_cyc[rise_b_n] = cyc;
               rise_b_n++;
            end
            if_b.pwm_in = (ph_b < 5);
            ph_b = (ph_b == 9) ? 0 : ph_b + 1;
         end
      end
   end

   function automatic bit out_lvl(input bit sel);
      return sel ? if_b.pwm_out : if_a.pwm_out;
   endfunction

   task automatic wait_rise(input bit sel, input int limit, output bit ok);
      bit prev;
      ok   = 1'b0;
      prev = out_lvl(sel);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (!prev && out_lvl(sel)) begin
            ok = 1'b1;
            return;
         end
         prev = out_lvl(sel);
      end
   endtask

   // Called on the sample where pwm_out just rose; returns on the next rise.
   task automatic count_period(input bit sel, output int hi, output int lo);
      hi = 1;
      lo = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (out_lvl(sel)) hi++;
         else break;
      end
      lo = 1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!out_lvl(sel)) lo++;
         else break;
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (if_a.pwm_out !== 1'b0) begin n_bad++; $display("FAIL rst_a_pwm_out: got %b want 0", if_a.pwm_out); end
      n_cmp++; if (if_a.locked !== 1'b0) begin n_bad++; $display("FAIL rst_a_locked: got %b want 0", if_a.locked); end
      n_cmp++; if (if_a.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_a_overflow: got %b want 0", if_a.overflow); end
      n_cmp++; if (if_b.pwm_out !== 1'b0) begin n_bad++; $display("FAIL rst_b_pwm_out: got %b want 0", if_b.pwm_out); end
      n_cmp++; if (if_b.locked !== 1'b0) begin n_bad++; $display("FAIL rst_b_locked: got %b want 0", if_b.locked); end
      n_cmp++; if (if_b.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_b_overflow: got %b want 0", if_b.overflow); end
      rst_a = 1'b1;
      rst_b = 1'b1;
   endtask

   task automatic test_div4_lock();
      bit ok;
      int hi, lo;
      hi_a = 3; lo_a = 7; mode_a = 2;
      wait_rise(1'b0, 200, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL div4_first_rise: got %b want 1", ok); end
      n_cmp++; if (if_a.locked !== 1'b1) begin n_bad++; $display("FAIL div4_locked: got %b want 1", if_a.locked); end
      for (int p = 0; p < 2; p++) begin
         count_period(1'b0, hi, lo);
         n_cmp++; if (hi !== 12) begin n_bad++; $display("FAIL div4_high p%0d: got %0d want 12", p, hi); end
         n_cmp++; if (lo !== 28) begin n_bad++; $display("FAIL div4_low p%0d: got %0d want 28", p, lo); end
      end
      n_cmp++; if (if_a.locked !== 1'b1) begin n_bad++; $display("FAIL div4_locked_after: got %b want 1", if_a.locked); end
   endtask

   task automatic test_div25_latency();
      bit ok;
      int hi, lo;
      mode_b = 1;
      wait_rise(1'b1, 100, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL div25_first_rise: got %b want 1", ok); end
      n_cmp++; if (cyc !== rise_b_cyc[1] + 4) begin n_bad++; $display("FAIL div25_latency: got cycle %0d want %0d", cyc, rise_b_cyc[1] + 4); end
      count_period(1'b1, hi, lo);
      n_cmp++; if (hi !== 125) begin n_bad++; $display("FAIL div25_high: got %0d want 125", hi); end
      n_cmp++; if (lo !== 125) begin n_bad++; $display("FAIL div25_low: got %0d want 125", lo); end
      n_cmp++; if (if_b.locked !== 1'b1) begin n_bad++; $display("FAIL div25_locked: got %b want 1", if_b.locked); end
   endtask

   task automatic test_duty_change();
      bit ok;
      int hi, lo;
      int exp_hi [3] = '{12, 24, 24};
      int exp_lo [3] = '{28, 16, 16};
      wait_rise(1'b0, 100, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL duty_rise: got %b want 1", ok); end
      hi_a = 6; lo_a = 4;
      for (int p = 0; p < 3; p++) begin
         count_period(1'b0, hi, lo);
         n_cmp++; if (hi !== exp_hi[p]) begin n_bad++; $display("FAIL duty_high p%0d: got %0d want %0d", p, hi, exp_hi[p]); end
         n_cmp++; if (lo !== exp_lo[p]) begin n_bad++; $display("FAIL duty_low p%0d: got %0d want %0d", p, lo, exp_lo[p]); end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      int hi, lo;
      n_cmp++; if (if_a.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pre: got %b want 0", if_a.overflow); end
      mode_a = 1;
      repeat (200) @(negedge clk);
      n_cmp++; if (if_a.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", if_a.overflow); end
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (if_a.overflow) begin ok = 1'b1; break; end
      end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ok); end
      n_cmp++; if (if_a.pwm_out !== 1'b0) begin n_bad++; $display("FAIL ovf_pwm_out: got %b want 0", if_a.pwm_out); end
      n_cmp++; if (if_a.locked !== 1'b0) begin n_bad++; $display("FAIL ovf_locked: got %b want 0", if_a.locked); end
      hi_a = 3; lo_a = 7; mode_a = 2;
      wait_rise(1'b0, 200, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_resume: got %b want 1", ok); end
      n_cmp++; if (if_a.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", if_a.overflow); end
      count_period(1'b0, hi, lo);
      n_cmp++; if (hi !== 12) begin n_bad++; $display("FAIL ovf_resume_high: got %0d want 12", hi); end
      n_cmp++; if (lo !== 28) begin n_bad++; $display("FAIL ovf_resume_low: got %0d want 28", lo); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int hi, lo;
      int glitches;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      n_cmp++; if (if_a.pwm_out !== 1'b0) begin n_bad++; $display("FAIL rmid_pwm_out: got %b want 0", if_a.pwm_out); end
      n_cmp++; if (if_a.locked !== 1'b0) begin n_bad++; $display("FAIL rmid_locked: got %b want 0", if_a.locked); end
      n_cmp++; if (if_a.overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_overflow: got %b want 0", if_a.overflow); end
      glitches = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if_a.pwm_out || if_a.locked) glitches++;
      end
      n_cmp++; if (glitches !== 0) begin n_bad++; $display("FAIL rmid_no_partial: got %0d active cycles want 0", glitches); end
      wait_rise(1'b0, 200, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rmid_resume: got %b want 1", ok); end
      count_period(1'b0, hi, lo);
      count_period(1'b0, hi, lo);
      n_cmp++; if (hi !== 12) begin n_bad++; $display("FAIL rmid_high: got %0d want 12", hi); end
      n_cmp++; if (lo !== 28) begin n_bad++; $display("FAIL rmid_low: got %0d want 28", lo); end
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      test_reset();
      test_div4_lock();
      test_div25_latency();
      test_duty_change();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
